matmul_tile_engine: RTL and testbench



---
 rtl/matmul_tile_engine.sv | 201 ++++++++++++++++++++
 tb/tb_matmul_tile_engine.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_tile_engine.sv
// Sequencer for an external N x N weight-stationary systolic array: loads weights, streams skewed X vectors, de-skews results.
// Optional MATMUL_RELU_EN clamps negative result lanes to zero in the output register stage.
module matmul_tile_engine #(
  parameter int N = 4,
  parameter int DW = 16,
  parameter int ACC_W = 32,
  parameter int AW = 8,
  parameter logic [AW-1:0] IN_BASE = 8'h00,
  parameter logic [AW-1:0] OUT_BASE = 8'h10,
  parameter int ARR_LAT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [AW-1:0]      num_vec,
  output logic               busy,
  output logic               done,
  output logic [AW-1:0]      din_addr,
  input  logic [N*DW-1:0]    din_data,
  output logic [AW-1:0]      dout_addr,
  output logic [N*ACC_W-1:0] dout_data,
  output logic               dout_we,
  output logic               arr_en,
  output logic [1:0]         arr_inst,
  output logic [N*DW-1:0]    arr_w,
  output logic [N*DW-1:0]    arr_x,
  input  logic [N*ACC_W-1:0] arr_s,
  output logic [2:0]         dbg_state
);
  typedef enum logic [2:0] {S_IDLE, S_LOAD_W, S_STREAM, S_DRAIN, S_FIN} state_t;
  localparam logic [1:0] INST_IDLE = 2'b00;
  localparam logic [1:0] INST_LOAD = 2'b01;
  localparam logic [1:0] INST_COMP = 2'b10;
  // A vector read in STREAM reaches its aligned result cycle ARR_LAT+N cycles after its data returns.
  localparam int VP = ARR_LAT + N;

  state_t             r_state;
  logic               r_busy, r_done, r_arr_en, r_w_valid, r_x_valid, r_dout_we;
  logic [1:0]         r_arr_inst;
  logic [AW-1:0]      r_din_addr, r_dout_addr, r_nv, r_cnt;
  logic [AW:0]        r_wr_cnt;
  logic [VP-1:0]      r_vpipe;
  logic [N*ACC_W-1:0] r_dout_data;
  logic [N*ACC_W-1:0] w_res;
  logic               w_last_wr;

  assign w_last_wr = r_dout_we && ((r_wr_cnt + 1'b1) == {1'b0, r_nv});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_arr_en   <= 1'b0;
      r_arr_inst <= INST_IDLE;
      r_din_addr <= IN_BASE;
      r_nv       <= '0;
      r_cnt      <= '0;
      r_w_valid  <= 1'b0;
      r_x_valid  <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_w_valid <= 1'b0;
      r_x_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_nv       <= num_vec;
            r_busy     <= 1'b1;
            r_arr_en   <= 1'b1;
            r_arr_inst <= INST_LOAD;
            r_cnt      <= '0;
            r_din_addr <= IN_BASE;
            r_state    <= S_LOAD_W;
          end
        end
        S_LOAD_W: begin
          if (r_cnt < AW'(N)) begin
            r_w_valid  <= 1'b1;
            r_din_addr <= r_din_addr + 1'b1;
            r_cnt      <= r_cnt + 1'b1;
          end else begin
            r_cnt <= '0;
            if (r_nv == '0) begin
              r_state    <= S_FIN;
              r_done     <= 1'b1;
              r_busy     <= 1'b0;
              r_arr_en   <= 1'b0;
              r_arr_inst <= INST_IDLE;
              r_din_addr <= IN_BASE;
            end else begin
              r_arr_inst <= INST_COMP;
              r_state    <= S_STREAM;
            end
          end
        end
        S_STREAM: begin
          r_x_valid  <= 1'b1;
          r_din_addr <= r_din_addr + 1'b1;
          r_cnt      <= r_cnt + 1'b1;
          if (r_cnt == r_nv - 1'b1) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (w_last_wr) begin
            r_state    <= S_FIN;
            r_done     <= 1'b1;
            r_busy     <= 1'b0;
            r_arr_en   <= 1'b0;
            r_arr_inst <= INST_IDLE;
            r_din_addr <= IN_BASE;
          end
        end
        S_FIN: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Output stage: the valid token rides alongside the data through skew, array and de-skew.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vpipe     <= '0;
      r_dout_we   <= 1'b0;
      r_dout_data <= '0;
      r_dout_addr <= OUT_BASE;
      r_wr_cnt    <= '0;
    end else begin
      r_vpipe   <= {r_vpipe[VP-2:0], r_x_valid};
      r_dout_we <= r_vpipe[VP-1];
      if (r_vpipe[VP-1]) r_dout_data <= w_res;
      if (r_state == S_IDLE && start) begin
        r_wr_cnt    <= '0;
        r_dout_addr <= OUT_BASE;
      end else if (r_dout_we) begin
        r_wr_cnt    <= r_wr_cnt + 1'b1;
        r_dout_addr <= w_last_wr ? OUT_BASE : r_dout_addr + 1'b1;
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane_x
    logic [DW-1:0] w_xin;
    logic [DW-1:0] r_xo;
    assign w_xin = r_x_valid ? din_data[i*DW +: DW] : '0;
    assign arr_x[i*DW +: DW] = r_xo;
    assign arr_w[i*DW +: DW] = r_w_valid ? din_data[i*DW +: DW] : '0;
    if (i == 0) begin : g_direct
      always_ff @(posedge clk) begin
        if (rst) r_xo <= '0;
        else     r_xo <= w_xin;
      end
    end else begin : g_line
      logic [DW-1:0] r_line [i];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int k = 0; k < i; k++) r_line[k] <= '0;
          r_xo <= '0;
        end else begin
          r_line[0] <= w_xin;
          for (int k = 1; k < i; k++) r_line[k] <= r_line[k-1];
          r_xo <= r_line[i-1];
        end
      end
    end
  end

  // Column j arrives j cycles after column 0; delay it N-1-j so every lane lines up with column N-1.
  for (genvar j = 0; j < N; j++) begin : g_lane_s
    localparam int D = N - 1 - j;
    logic [ACC_W-1:0] w_al;
    if (D == 0) begin : g_direct
      assign w_al = arr_s[j*ACC_W +: ACC_W];
    end else begin : g_line
      logic [ACC_W-1:0] r_dl [D];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int k = 0; k < D; k++) r_dl[k] <= '0;
        end else begin
          r_dl[0] <= arr_s[j*ACC_W +: ACC_W];
          for (int k = 1; k < D; k++) r_dl[k] <= r_dl[k-1];
        end
      end
      assign w_al = r_dl[D-1];
    end
`ifdef MATMUL_RELU_EN
    assign w_res[j*ACC_W +: ACC_W] = w_al[ACC_W-1] ? '0 : w_al;
`else
    assign w_res[j*ACC_W +: ACC_W] = w_al;
`endif
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign din_addr  = r_din_addr;
  assign dout_addr = r_dout_addr;
  assign dout_data = r_dout_data;
  assign dout_we   = r_dout_we;
  assign arr_en    = r_arr_en;
  assign arr_inst  = r_arr_inst;
  assign dbg_state = r_state;
endmodule

// File: tb/tb_matmul_tile_engine.sv
// Bench for matmul_tile_engine: block-RAM and systolic-array models around the DUT, scoreboard of expected result rows.
module tb_matmul_tile_engine;
  localparam int N = 4;
  localparam int DW = 16;
  localparam int ACC_W = 32;
  localparam int AW = 8;
  localparam int ARR_LAT = 4;
  localparam logic [AW-1:0] IN_BASE = 8'h00;
  localparam logic [AW-1:0] OUT_BASE = 8'h10;

  logic clk = 1'b0;
  logic rst, start;
  logic [AW-1:0] num_vec;
  logic busy, done, dout_we, arr_en;
  logic [AW-1:0] din_addr, dout_addr;
  logic [N*DW-1:0] din_data, arr_w, arr_x;
  logic [N*ACC_W-1:0] dout_data, arr_s;
  logic [1:0] arr_inst;
  logic [2:0] dbg_state;

  matmul_tile_engine #(.N(N), .DW(DW), .ACC_W(ACC_W), .AW(AW), .IN_BASE(IN_BASE),
                       .OUT_BASE(OUT_BASE), .ARR_LAT(ARR_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .num_vec(num_vec), .busy(busy), .done(done),
    .din_addr(din_addr), .din_data(din_data), .dout_addr(dout_addr), .dout_data(dout_data),
    .dout_we(dout_we), .arr_en(arr_en), .arr_inst(arr_inst), .arr_w(arr_w), .arr_x(arr_x),
    .arr_s(arr_s), .dbg_state(dbg_state)
  );

  // Clock and memory with one-cycle read latency
  always #5 clk = ~clk;
  logic [N*DW-1:0] mem [256];
  always @(posedge clk) din_data <= mem[din_addr];

  // Array model: weights shift in from the bottom row; column j sums W[k][j]*x_k with skew timing
  logic signed [DW-1:0] wm [N][N];
  logic [N*DW-1:0] xh [64];
  int acyc = 100;
  always @(negedge clk) begin : arr_model
    longint acc;
    logic [N*DW-1:0] xs;
    xs = (arr_en && arr_inst == 2'b10) ? arr_x : '0;
    xh[acyc % 64] = xs;
    for (int j = 0; j < N; j++) begin
      acc = 0;
      for (int k = 0; k < N; k++) begin
        xs = xh[(acyc - ARR_LAT - j + k) % 64];
        acc += longint'(wm[k][j]) * longint'($signed(xs[k*DW +: DW]));
      end
      arr_s[j*ACC_W +: ACC_W] = acc[ACC_W-1:0];
    end
    if (arr_en && arr_inst == 2'b01) begin
      for (int r = 0; r < N-1; r++) wm[r] = wm[r+1];
      for (int c = 0; c < N; c++) wm[N-1][c] = arr_w[c*DW +: DW];
    end
    acyc++;
  end

  // Scoreboard and observations
  int n_checks = 0;
  int n_fail = 0;
  logic [N*ACC_W-1:0] exp_q[$];
  logic [AW-1:0] exp_a_q[$];
  logic [N*ACC_W-1:0] obs_data[$];
  logic [AW-1:0] obs_addr[$];
  int obs_load, obs_done, obs_gap, inject_cyc, inject_nv;
  bit obs_timeout, obs_busy_start, obs_busy_end, obs_base_ok;

  function automatic logic [N*DW-1:0] pack(input int a0, input int a1, input int a2, input int a3);
    logic [N*DW-1:0] p;
    p[0*DW +: DW] = DW'(a0);
    p[1*DW +: DW] = DW'(a1);
    p[2*DW +: DW] = DW'(a2);
    p[3*DW +: DW] = DW'(a3);
    return p;
  endfunction

  task automatic rand_fill();
    for (int a = 0; a < 256; a++)
      for (int l = 0; l < N; l++) mem[a][l*DW +: DW] = DW'($urandom);
  endtask

  task automatic set_identity();
    for (int k = 0; k < N; k++) mem[AW'(int'(IN_BASE) + k)] = pack(k == 0, k == 1, k == 2, k == 3);
  endtask

  // Result row v lane j = sum_k W[k][j] * X_v[k], W row k at IN_BASE+k, X_v at IN_BASE+N+v (address wraps)
  task automatic push_expected(input int nv);
    logic [N*ACC_W-1:0] row;
    logic [N*DW-1:0] xv, wr;
    logic [ACC_W-1:0] r;
    longint acc;
    for (int v = 0; v < nv; v++) begin
      xv = mem[AW'(int'(IN_BASE) + N + v)];
      for (int j = 0; j < N; j++) begin
        acc = 0;
        for (int k = 0; k < N; k++) begin
          wr = mem[AW'(int'(IN_BASE) + k)];
          acc += longint'($signed(wr[j*DW +: DW])) * longint'($signed(xv[k*DW +: DW]));
        end
        r = acc[ACC_W-1:0];
`ifdef MATMUL_RELU_EN
        if (r[ACC_W-1]) r = '0;
`endif
        row[j*ACC_W +: ACC_W] = r;
      end
      exp_q.push_back(row);
      exp_a_q.push_back(AW'(int'(OUT_BASE) + v));
    end
  endtask

  // Driver: launches one job and records what the DUT does until a few cycles past done
  task automatic run_job(input int nv);
    int last_we, extra;
    bit seen;
    obs_data.delete(); obs_addr.delete();
    obs_load = 0; obs_done = 0; obs_gap = -1; obs_timeout = 0; obs_base_ok = 0;
    last_we = -100; extra = 0; seen = 0;
    @(negedge clk); start = 1'b1; num_vec = AW'(nv);
    @(negedge clk); start = 1'b0; obs_busy_start = busy;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (arr_en && arr_inst == 2'b01) obs_load++;
      if (dout_we) begin obs_addr.push_back(dout_addr); obs_data.push_back(dout_data); last_we = cyc; end
      if (done) begin
        obs_done++;
        if (!seen) begin
          obs_gap = cyc - last_we;
          obs_base_ok = (din_addr == IN_BASE) && (dout_addr == OUT_BASE) && !busy && !arr_en;
        end
        seen = 1;
      end
      if (seen) extra++;
      if (extra > 4) break;
      if (cyc == inject_cyc) begin start = 1'b1; num_vec = AW'(inject_nv); end
      else start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    obs_timeout = !seen;
    obs_busy_end = busy;
  endtask

  task automatic test_reset();
    @(negedge clk); rst = 1'b1; start = 1'b1; num_vec = 8'd3;
    repeat (3) @(negedge clk);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%0b exp=0", done); end
    n_checks++; if (dout_we !== 1'b0) begin n_fail++; $display("FAIL reset_we got=%0b exp=0", dout_we); end
    n_checks++; if (arr_en !== 1'b0) begin n_fail++; $display("FAIL reset_arr_en got=%0b exp=0", arr_en); end
    n_checks++; if (arr_inst !== 2'b00) begin n_fail++; $display("FAIL reset_inst got=%b exp=00", arr_inst); end
    n_checks++; if (din_addr !== IN_BASE) begin n_fail++; $display("FAIL reset_din_addr got=%h exp=%h", din_addr, IN_BASE); end
    n_checks++; if (dout_addr !== OUT_BASE) begin n_fail++; $display("FAIL reset_dout_addr got=%h exp=%h", dout_addr, OUT_BASE); end
    n_checks++; if (arr_w !== '0) begin n_fail++; $display("FAIL reset_arr_w got=%h exp=0", arr_w); end
    n_checks++; if (arr_x !== '0) begin n_fail++; $display("FAIL reset_arr_x got=%h exp=0", arr_x); end
    n_checks++; if (dout_data !== '0) begin n_fail++; $display("FAIL reset_dout_data got=%h exp=0", dout_data); end
  endtask

  // Compares the recorded writes against the expected queue, then empties both sides
  task automatic test_job(input string name, input int nv);
    push_expected(nv);
    run_job(nv);
    n_checks++; if (obs_timeout) begin n_fail++; $display("FAIL %s_timeout got=no_done exp=done", name); end
    n_checks++; if (obs_busy_start !== 1'b1) begin n_fail++; $display("FAIL %s_busy got=%0b exp=1", name, obs_busy_start); end
    n_checks++; if (obs_addr.size() != exp_a_q.size()) begin n_fail++; $display("FAIL %s_writes got=%0d exp=%0d", name, obs_addr.size(), exp_a_q.size()); end
    for (int i = 0; i < obs_addr.size() && i < exp_a_q.size(); i++) begin
      n_checks++; if (obs_addr[i] !== exp_a_q[i]) begin n_fail++; $display("FAIL %s_addr[%0d] got=%h exp=%h", name, i, obs_addr[i], exp_a_q[i]); end
      n_checks++; if (obs_data[i] !== exp_q[i]) begin n_fail++; $display("FAIL %s_data[%0d] got=%h exp=%h", name, i, obs_data[i], exp_q[i]); end
    end
    n_checks++; if (obs_done != 1) begin n_fail++; $display("FAIL %s_done_count got=%0d exp=1", name, obs_done); end
    n_checks++; if (obs_load != N+1) begin n_fail++; $display("FAIL %s_load_cycles got=%0d exp=%0d", name, obs_load, N+1); end
    n_checks++; if (obs_base_ok !== 1'b1) begin n_fail++; $display("FAIL %s_fin_state got=%0b exp=1", name, obs_base_ok); end
    if (nv > 0) begin
      n_checks++; if (obs_gap != 1) begin n_fail++; $display("FAIL %s_done_gap got=%0d exp=1", name, obs_gap); end
    end
    exp_q.delete(); exp_a_q.delete();
  endtask

  task automatic test_identity();
    set_identity();
    mem[AW'(int'(IN_BASE) + N)] = pack(1, 2, 3, 4);
    mem[AW'(int'(IN_BASE) + N + 1)] = pack(-5, 6, -7, 8);
    test_job("identity", 2);
  endtask

  task automatic test_row_weights();
    for (int k = 0; k < N; k++) mem[AW'(int'(IN_BASE) + k)] = pack(k+1, k+1, k+1, k+1);
    mem[AW'(int'(IN_BASE) + N)] = pack(1, 1, 1, 1);
    test_job("row_weights", 1);
    for (int j = 0; j < N && obs_data.size() > 0; j++) begin
      n_checks++;
      if (obs_data[0][j*ACC_W +: ACC_W] !== 32'd10) begin
        n_fail++; $display("FAIL row_weights_lane%0d got=%0d exp=10", j, obs_data[0][j*ACC_W +: ACC_W]);
      end
    end
  endtask

  task automatic test_relu();
    set_identity();
    mem[AW'(int'(IN_BASE) + N)] = pack(-1, 2, -3, 4);
    test_job("relu", 1);
  endtask

  task automatic test_zero_vec();
    rand_fill();
    test_job("zero_vec", 0);
  endtask

  task automatic test_start_ignored();
    rand_fill();
    inject_cyc = 2; inject_nv = 9;
    test_job("start_in_load", 3);
    inject_cyc = 6; inject_nv = 12;
    test_job("start_in_stream", 3);
    inject_cyc = -1;
    n_checks++; if (obs_busy_end !== 1'b0) begin n_fail++; $display("FAIL start_ignored_idle got=%0b exp=0", obs_busy_end); end
  endtask

  task automatic test_reset_mid();
    int wes, dns;
    rand_fill();
    @(negedge clk); start = 1'b1; num_vec = 8'd8;
    @(negedge clk); start = 1'b0;
    repeat (7) @(negedge clk);
    n_checks++; if (arr_inst !== 2'b10) begin n_fail++; $display("FAIL midrst_streaming got=%b exp=10", arr_inst); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got=%0b exp=0", busy); end
    n_checks++; if (arr_en !== 1'b0) begin n_fail++; $display("FAIL midrst_arr_en got=%0b exp=0", arr_en); end
    n_checks++; if (arr_inst !== 2'b00) begin n_fail++; $display("FAIL midrst_inst got=%b exp=00", arr_inst); end
    n_checks++; if (din_addr !== IN_BASE) begin n_fail++; $display("FAIL midrst_din_addr got=%h exp=%h", din_addr, IN_BASE); end
    n_checks++; if (dout_addr !== OUT_BASE) begin n_fail++; $display("FAIL midrst_dout_addr got=%h exp=%h", dout_addr, OUT_BASE); end
    n_checks++; if (arr_x !== '0) begin n_fail++; $display("FAIL midrst_arr_x got=%h exp=0", arr_x); end
    n_checks++; if (dout_data !== '0) begin n_fail++; $display("FAIL midrst_dout_data got=%h exp=0", dout_data); end
    wes = 0; dns = 0;
    for (int c = 0; c < 30; c++) begin
      if (dout_we) wes++;
      if (done) dns++;
      @(negedge clk);
    end
    n_checks++; if (wes != 0) begin n_fail++; $display("FAIL midrst_no_writes got=%0d exp=0", wes); end
    n_checks++; if (dns != 0) begin n_fail++; $display("FAIL midrst_no_done got=%0d exp=0", dns); end
    rand_fill();
    test_job("after_reset", 5);
  endtask

  task automatic test_random();
    for (int t = 0; t < 5; t++) begin
      rand_fill();
      test_job("random", $urandom_range(1, 12));
    end
    rand_fill();
    test_job("max_vec", 255);
  endtask

  initial begin
    for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) wm[r][c] = '0;
    for (int i = 0; i < 64; i++) xh[i] = '0;
    for (int a = 0; a < 256; a++) mem[a] = '0;
    rst = 1'b1; start = 1'b0; num_vec = '0; inject_cyc = -1; inject_nv = 0;
    test_reset();
    test_identity();
    test_row_weights();
    test_relu();
    test_zero_vec();
    test_start_ignored();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
